// File: rtl/pipelined_prefix_subtractor_if.sv
// Operand and result handshake bundle for the pipelined prefix subtractor.
// The master side is the surrounding environment: it produces operands and
// consumes results. The slave side is the subtractor itself.
interface pipelined_prefix_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/pipelined_prefix_subtractor.sv
// Three-stage subtractor: diff = a - b - bin, computed as a + ~b + ~bin through
// a Sklansky parallel-prefix carry network. Stage 1 holds generate/propagate,
// stage 2 holds the prefix carries, stage 3 holds the result. Each stage has
// its own valid bit so bubbles collapse and either side may stall.
module pipelined_prefix_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    pipelined_prefix_subtractor_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);

    logic v1, v2, v3;
    logic rdy1, rdy2, rdy3;

    // Ready ripples backwards from the consumer; a stage can take a new beat
    // if it is empty or its current beat is moving on this cycle.
    assign rdy3        = !v3 || bus.out_ready;
    assign rdy2        = !v2 || rdy3;
    assign rdy1        = !v1 || rdy2;
    assign bus.in_ready = rdy1;

    // Subtraction as addition of the inverted subtrahend.
    logic [WIDTH-1:0] g0, p0;
    assign g0 = bus.a & ~bus.b;
    assign p0 = bus.a ^ ~bus.b;

    logic [WIDTH-1:0] g1, p1;
    logic             cin1, a_msb1, b_msb1;

    // Stage 1: capture per-bit generate/propagate and the carry-in (inverted borrow).
    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            g1     <= '0;
            p1     <= '0;
            cin1   <= 1'b0;
            a_msb1 <= 1'b0;
            b_msb1 <= 1'b0;
        end else if (rdy1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                g1     <= g0;
                p1     <= p0;
                cin1   <= ~bus.bin;
                a_msb1 <= bus.a[WIDTH-1];
                b_msb1 <= bus.b[WIDTH-1];
            end
        end
    end

    logic [WIDTH-1:0] gl [LEVELS+1];
    logic [WIDTH-1:0] pl [LEVELS+1];
    logic [WIDTH-1:0] gg;

    // Sklansky black-cell levels give group (G,P) over [i:0]; the final grey
    // cell folds in the carry-in pseudo-bit so gg[i] is the carry out of bit i.
    always_comb begin
        gl[0] = g1;
        pl[0] = p1;
        for (int l = 0; l < LEVELS; l++) begin
            gl[l+1] = gl[l];
            pl[l+1] = pl[l];
            for (int i = 0; i < WIDTH; i++) begin
                if (((i >> l) & 1) == 1) begin
                    int j;
                    j = ((i >> l) << l) - 1;
                    gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][j]);
                    pl[l+1][i] = pl[l][i] & pl[l][j];
                end
            end
        end
        gg = gl[LEVELS] | (pl[LEVELS] & {WIDTH{cin1}});
    end

    logic [WIDTH-2:0] gg2;
    logic [WIDTH-1:0] p2;
    logic             cin2, cout2, a_msb2, b_msb2;

    // Stage 2: capture carries into bits 1..W-1, the carry-out and the propagate vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            gg2    <= '0;
            p2     <= '0;
            cin2   <= 1'b0;
            cout2  <= 1'b0;
            a_msb2 <= 1'b0;
            b_msb2 <= 1'b0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                gg2    <= gg[WIDTH-2:0];
                p2     <= p1;
                cin2   <= cin1;
                cout2  <= gg[WIDTH-1];
                a_msb2 <= a_msb1;
                b_msb2 <= b_msb1;
            end
        end
    end

    logic [WIDTH-1:0] diff_c;
    logic             ovf_c;
    assign diff_c = p2 ^ {gg2, cin2};
    assign ovf_c  = (a_msb2 != b_msb2) && (diff_c[WIDTH-1] != a_msb2);

    logic [WIDTH-1:0] diff3;
    logic             bout3, ovf3;

    // Stage 3: result register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3    <= 1'b0;
            diff3 <= '0;
            bout3 <= 1'b0;
            ovf3  <= 1'b0;
        end else if (rdy3) begin
            v3 <= v2;
            if (v2) begin
                diff3 <= diff_c;
                bout3 <= ~cout2;
                ovf3  <= ovf_c;
            end
        end
    end

    assign bus.out_valid = v3;
    assign bus.diff      = diff3;
    assign bus.bout      = bout3;
    assign bus.ovf       = ovf3;
endmodule
